// File: rtl/sobel_out_arbiter.sv
// Round-robin arbiter that serializes BURST_LEN-pixel bursts from two Sobel cores
// into single-pixel writes on one BRAM port, one beat per cycle.
module sobel_out_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 5
) (
  input  logic                          clka,
  input  logic                          reset,
  input  logic                          req_0,
  input  logic [ADDR_W-1:0]             base_addr_0,
  input  logic [BURST_LEN*DATA_W-1:0]   data_0,
  input  logic [BURST_LEN-1:0]          mask_0,
  output logic                          gnt_0,
  input  logic                          req_1,
  input  logic [ADDR_W-1:0]             base_addr_1,
  input  logic [BURST_LEN*DATA_W-1:0]   data_1,
  input  logic [BURST_LEN-1:0]          mask_1,
  output logic                          gnt_1,
  output logic                          bram_ena,
  output logic                          bram_wea,
  output logic [ADDR_W-1:0]             bram_addra,
  output logic [DATA_W-1:0]             bram_dina,
  output logic                          busy,
  output logic [31:0]                   wr_count
);

  // Handshake: a requester holds req with a stable payload until it sees the
  // one-cycle gnt pulse; the payload is captured on the edge that raises gnt.
  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          r_last;
  logic [IDX_W-1:0]              r_idx;
  logic [ADDR_W-1:0]             r_base;
  logic [BURST_LEN*DATA_W-1:0]   r_data;
  logic [BURST_LEN-1:0]          r_mask;

  logic                          w_last_beat;
  logic                          w_arb;
  logic                          w_gnt_0;
  logic                          w_gnt_1;
  logic                          w_grant;
  logic [ADDR_W-1:0]             w_beat_addr;
  logic [DATA_W-1:0]             w_beat_data;
  logic                          w_beat_we;

  // Arbitration runs when idle and on the final beat, so bursts chain gaplessly.
  always_comb begin
    w_last_beat = (r_state == WRITE) && (r_idx == LAST_IDX);
    w_arb       = (r_state == IDLE) || w_last_beat;
    w_gnt_0     = w_arb && req_0 && (!req_1 || r_last);
    w_gnt_1     = w_arb && req_1 && (!req_0 || !r_last);
    w_grant     = w_gnt_0 || w_gnt_1;
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = WRITE;
      WRITE:   if (w_last_beat && !w_grant) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_beat_addr = r_base + ADDR_W'(r_idx);
    w_beat_data = r_data[r_idx*DATA_W +: DATA_W];
    w_beat_we   = r_mask[r_idx];
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      gnt_0      <= 1'b0;
      gnt_1      <= 1'b0;
      bram_ena   <= 1'b0;
      bram_wea   <= 1'b0;
      bram_addra <= '0;
      bram_dina  <= '0;
      busy       <= 1'b0;
      wr_count   <= '0;
      r_idx      <= '0;
      r_last     <= 1'b1;
      r_base     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
    end else begin
      gnt_0    <= w_gnt_0;
      gnt_1    <= w_gnt_1;
      bram_ena <= 1'b0;
      bram_wea <= 1'b0;
      busy     <= (r_state == WRITE);
      if (r_state == WRITE) begin
        bram_addra <= w_beat_addr;
        bram_dina  <= w_beat_data;
        bram_ena   <= w_beat_we;
        bram_wea   <= w_beat_we;
        if (w_beat_we) wr_count <= wr_count + 32'd1;
        r_idx <= w_last_beat ? '0 : r_idx + IDX_W'(1);
      end
      // A new grant on the final beat overwrites the payload after that beat has
      // already been taken from the old registers above.
      if (w_grant) begin
        r_idx  <= '0;
        r_last <= w_gnt_1;
        r_base <= w_gnt_1 ? base_addr_1 : base_addr_0;
        r_data <= w_gnt_1 ? data_1      : data_0;
        r_mask <= w_gnt_1 ? mask_1      : mask_0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_out_arbiter.sv
// Directed bench for sobel_out_arbiter: cycle-by-cycle beat checks plus a
// write-port scoreboard fed from an expected queue.
module tb_sobel_out_arbiter;

  logic        clka;
  logic        reset;
  logic        req_0, req_1;
  logic [15:0] base_addr_0, base_addr_1;
  logic [39:0] data_0, data_1;
  logic [4:0]  mask_0, mask_1;
  logic        gnt_0, gnt_1;
  logic        bram_ena, bram_wea;
  logic [15:0] bram_addra;
  logic [7:0]  bram_dina;
  logic        busy;
  logic [31:0] wr_count;

  int          n_checks;
  int          n_pass;
  logic [31:0] exp_wr;
  logic [23:0] exp_q[$];

  sobel_out_arbiter #(.ADDR_W(16), .DATA_W(8), .BURST_LEN(5)) dut (
    .clka(clka), .reset(reset),
    .req_0(req_0), .base_addr_0(base_addr_0), .data_0(data_0), .mask_0(mask_0), .gnt_0(gnt_0),
    .req_1(req_1), .base_addr_1(base_addr_1), .data_1(data_1), .mask_1(mask_1), .gnt_1(gnt_1),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .busy(busy), .wr_count(wr_count)
  );

  // clock / reset
  initial clka = 1'b0;
  always #5 clka = ~clka;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // scoreboard: every enabled write must match the head of exp_q
  always @(negedge clka) begin
    if (!reset && bram_ena) begin
      if (exp_q.size() == 0) check("wr_unexpected", {63'd0, bram_ena}, 64'd0);
      else check("wr_port", {40'd0, bram_addra, bram_dina}, {40'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_0 = 1'b0;
    req_1 = 1'b0;
    exp_wr = '0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic set_req0(input logic [15:0] b, input logic [39:0] d, input logic [4:0] m);
    req_0 = 1'b1; base_addr_0 = b; data_0 = d; mask_0 = m;
  endtask

  task automatic set_req1(input logic [15:0] b, input logic [39:0] d, input logic [4:0] m);
    req_1 = 1'b1; base_addr_1 = b; data_1 = d; mask_1 = m;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ena"},  {63'd0, bram_ena}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_gnt"},  {62'd0, gnt_1, gnt_0}, 64'd0);
    check({tag, "_wrcnt"}, {32'd0, wr_count}, {32'd0, exp_wr});
  endtask

  // Walks the five beats of a granted burst; eg0/eg1 are the grants expected
  // alongside the final beat.
  task automatic beats(input string tag, input logic [15:0] base, input logic [39:0] d,
                       input logic [4:0] m, input logic eg0, input logic eg1);
    logic [15:0] a;
    for (int i = 0; i < 5; i++) begin
      a = base + 16'(i);
      if (m[i]) begin
        exp_q.push_back({a, d[i*8 +: 8]});
        exp_wr = exp_wr + 32'd1;
      end
    end
    for (int i = 0; i < 5; i++) begin
      step();
      a = base + 16'(i);
      check($sformatf("%s_b%0d_ena", tag, i), {63'd0, bram_ena}, {63'd0, m[i]});
      check($sformatf("%s_b%0d_wea", tag, i), {63'd0, bram_wea}, {63'd0, m[i]});
      check($sformatf("%s_b%0d_addr", tag, i), {48'd0, bram_addra}, {48'd0, a});
      check($sformatf("%s_b%0d_data", tag, i), {56'd0, bram_dina}, {56'd0, d[i*8 +: 8]});
      check($sformatf("%s_b%0d_busy", tag, i), {63'd0, busy}, 64'd1);
      if (i == 4) check($sformatf("%s_b%0d_gnt", tag, i), {62'd0, gnt_1, gnt_0}, {62'd0, eg1, eg0});
      else        check($sformatf("%s_b%0d_gnt", tag, i), {62'd0, gnt_1, gnt_0}, 64'd0);
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; exp_wr = '0;
    reset = 1'b1; req_0 = 1'b0; req_1 = 1'b0;
    base_addr_0 = '0; base_addr_1 = '0; data_0 = '0; data_1 = '0; mask_0 = '0; mask_1 = '0;
    do_reset();
    check("rst_addr", {48'd0, bram_addra}, 64'd0);
    check("rst_dina", {56'd0, bram_dina}, 64'd0);
    check_idle("rst");

    // 1: single burst from requester 0
    set_req0(16'h0100, {8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 5'b11111);
    step();
    check("t1_gnt", {62'd0, gnt_1, gnt_0}, 64'd1);
    check("t1_busy_gnt", {63'd0, busy}, 64'd0);
    req_0 = 1'b0;
    beats("t1", 16'h0100, {8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 5'b11111, 1'b0, 1'b0);
    step();
    check_idle("t1_end");

    // 2: simultaneous requests after reset, back-to-back, then a retie
    do_reset();
    set_req0(16'h0300, 40'h0504030201, 5'b11111);
    set_req1(16'h0400, 40'h1514131211, 5'b11111);
    step();
    check("t2_gnt_a", {62'd0, gnt_1, gnt_0}, 64'd1);
    req_0 = 1'b0;
    beats("t2a", 16'h0300, 40'h0504030201, 5'b11111, 1'b0, 1'b1);
    set_req0(16'h0500, 40'h2524232221, 5'b11111);
    set_req1(16'h0600, 40'h3534333231, 5'b01111);
    beats("t2b", 16'h0400, 40'h1514131211, 5'b11111, 1'b1, 1'b0);
    req_0 = 1'b0;
    beats("t2c", 16'h0500, 40'h2524232221, 5'b11111, 1'b0, 1'b1);
    req_1 = 1'b0;
    beats("t2d", 16'h0600, 40'h3534333231, 5'b01111, 1'b0, 1'b0);
    step();
    check_idle("t2_end");

    // 3: requester 1 held high, requester 0 arrives mid-burst
    do_reset();
    set_req1(16'h0700, 40'h4544434241, 5'b11111);
    step();
    check("t3_gnt_a", {62'd0, gnt_1, gnt_0}, 64'd2);
    set_req1(16'h0900, 40'h6564636261, 5'b11111);
    set_req0(16'h0800, 40'h5554535251, 5'b11111);
    beats("t3a", 16'h0700, 40'h4544434241, 5'b11111, 1'b1, 1'b0);
    req_0 = 1'b0;
    beats("t3b", 16'h0800, 40'h5554535251, 5'b11111, 1'b0, 1'b1);
    req_1 = 1'b0;
    beats("t3c", 16'h0900, 40'h6564636261, 5'b11111, 1'b0, 1'b0);
    step();
    check_idle("t3_end");

    // 4: sparse mask, wr_count counts only enabled beats
    do_reset();
    set_req0(16'h2000, 40'hA5A4A3A2A1, 5'b10101);
    step();
    check("t4_gnt", {62'd0, gnt_1, gnt_0}, 64'd1);
    req_0 = 1'b0;
    beats("t4", 16'h2000, 40'hA5A4A3A2A1, 5'b10101, 1'b0, 1'b0);
    step();
    check_idle("t4_end");
    check("t4_wrcnt3", {32'd0, wr_count}, 64'd3);

    // 5: address wraps past the top of the BRAM
    set_req1(16'hFFFE, 40'hB5B4B3B2B1, 5'b11111);
    step();
    check("t5_gnt", {62'd0, gnt_1, gnt_0}, 64'd2);
    req_1 = 1'b0;
    beats("t5", 16'hFFFE, 40'hB5B4B3B2B1, 5'b11111, 1'b0, 1'b0);
    step();
    check_idle("t5_end");

    // 6: reset during beat 2, then normal grant with both requesting
    set_req0(16'h3000, 40'hC5C4C3C2C1, 5'b11111);
    step();
    check("t6_gnt", {62'd0, gnt_1, gnt_0}, 64'd1);
    req_0 = 1'b0;
    exp_q.push_back({16'h3000, 8'hC1});
    exp_q.push_back({16'h3001, 8'hC2});
    for (int i = 0; i < 3; i++) step();
    check("t6_b2_addr", {48'd0, bram_addra}, 64'h3002);
    check("t6_b2_ena", {63'd0, bram_ena}, 64'd1);
    #2;
    reset = 1'b1;
    exp_wr = '0;
    #1;
    check("t6_async_ena", {63'd0, bram_ena}, 64'd0);
    check("t6_async_addr", {48'd0, bram_addra}, 64'd0);
    check("t6_async_dina", {56'd0, bram_dina}, 64'd0);
    check("t6_async_wrcnt", {32'd0, wr_count}, 64'd0);
    check("t6_async_busy", {63'd0, busy}, 64'd0);
    set_req0(16'h3100, 40'hD5D4D3D2D1, 5'b11111);
    set_req1(16'h3200, 40'hE5E4E3E2E1, 5'b11111);
    step();
    check("t6_rst_wins", {62'd0, gnt_1, gnt_0}, 64'd0);
    check("t6_rst_ena", {63'd0, bram_ena}, 64'd0);
    reset = 1'b0;
    step();
    check("t6_gnt_after", {62'd0, gnt_1, gnt_0}, 64'd1);
    req_0 = 1'b0;
    beats("t6a", 16'h3100, 40'hD5D4D3D2D1, 5'b11111, 1'b0, 1'b1);
    req_1 = 1'b0;
    beats("t6b", 16'h3200, 40'hE5E4E3E2E1, 5'b11111, 1'b0, 1'b0);
    step();
    check_idle("t6_end");

    // final report
    step();
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
